// File: rtl/sha_block_unpack.sv
// sha_block_unpack: reads a padded SHA-256 block, validates padding, writes recovered bytes.
module sha_block_unpack #(
  parameter int MAX_MESSAGE_LENGTH = 55,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  xxx__dut__go,
  output logic                                  dut__xxx__finish,
  output logic                                  dut__xxx__error,
  output logic [$clog2(MAX_MESSAGE_LENGTH):0]   dut__xxx__msg_length,
  output logic [$clog2(BLOCK_WORDS)-1:0]        dut__bmem__address,
  output logic                                  dut__bmem__enable,
  output logic                                  dut__bmem__write,
  input  logic [31:0]                           bmem__dut__data,
  output logic [$clog2(MAX_MESSAGE_LENGTH)-1:0] dut__msg__address,
  output logic [7:0]                            dut__msg__data,
  output logic                                  dut__msg__enable,
  output logic                                  dut__msg__write
);
  localparam int LW = $clog2(MAX_MESSAGE_LENGTH) + 1;
  localparam int AW = $clog2(MAX_MESSAGE_LENGTH);
  localparam int BW = $clog2(BLOCK_WORDS);
  localparam int NB = BLOCK_WORDS * 4;
  localparam int CW = AW > BW + 1 ? AW : BW + 1;
  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NB*8-1:0] buf_q, buf_d;
  logic            finish_q, finish_d, error_q, error_d, ben_q, ben_d, men_q, men_d;
  logic [LW-1:0]   len_q, len_d;
  logic [BW-1:0]   baddr_q, baddr_d;
  logic [AW-1:0]   maddr_q, maddr_d;
  logic [7:0]      mdata_q, mdata_d, wbyte;
  logic [31:0]     l32;
  logic            pass;
  // Length comes from all of word 15 so oversized values fail the range check.
  always_comb begin
    l32 = {3'b000, buf_q[31:3]};
    pass = buf_q[63:32] == '0 && buf_q[2:0] == '0 && l32 <= MAX_MESSAGE_LENGTH;
    for (int i = 0; i < NB - 8; i++)
      pass = pass && (l32 == i ? buf_q[8*(NB-1-i) +: 8] == 8'h80 : (l32 > i || buf_q[8*(NB-1-i) +: 8] == 8'h00));
    wbyte = buf_q[8*(NB-1-int'(cnt_q)) +: 8];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      finish_q <= 1'b0;
      error_q  <= 1'b0;
      len_q    <= '0;
      ben_q    <= 1'b0;
      baddr_q  <= '0;
      men_q    <= 1'b0;
      maddr_q  <= '0;
      mdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      finish_q <= finish_d;
      error_q  <= error_d;
      len_q    <= len_d;
      ben_q    <= ben_d;
      baddr_q  <= baddr_d;
      men_q    <= men_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
    end
  end
  // Read data lags the issued address by two edges, so word cnt-1 is captured.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        state_d = xxx__dut__go ? READ : IDLE;
        cnt_d   = '0;
      end
      READ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0) buf_d[32*(BLOCK_WORDS-int'(cnt_q)) +: 32] = bmem__dut__data;
        if (cnt_q == CW'(BLOCK_WORDS)) state_d = CHECK;
      end
      CHECK: begin
        state_d = pass && l32 != '0 ? WRITE : DONE;
        cnt_d   = '0;
      end
      WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = LW'(cnt_q) + LW'(1) == len_q ? DONE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    finish_d = state_q == DONE;
    ben_d    = (state_q == IDLE && xxx__dut__go) || (state_q == READ && cnt_q < CW'(BLOCK_WORDS - 1));
    baddr_d  = state_q == READ && ben_d ? BW'(cnt_q + 1'b1) : '0;
    men_d    = state_q == WRITE;
    maddr_d  = men_d ? cnt_q[AW-1:0] : '0;
    mdata_d  = men_d ? wbyte : '0;
    error_d  = state_q == CHECK ? !pass : (state_q == IDLE && xxx__dut__go) ? 1'b0 : error_q;
    len_d    = state_q == CHECK && pass ? l32[LW-1:0] :
               (state_q == CHECK || (state_q == IDLE && xxx__dut__go)) ? '0 : len_q;
  end
  assign dut__xxx__finish     = finish_q;
  assign dut__xxx__error      = error_q;
  assign dut__xxx__msg_length = len_q;
  assign dut__bmem__address   = baddr_q;
  assign dut__bmem__enable    = ben_q;
  assign dut__bmem__write     = 1'b0;
  assign dut__msg__address    = maddr_q;
  assign dut__msg__data       = mdata_q;
  assign dut__msg__enable     = men_q;
  assign dut__msg__write      = men_q;
endmodule

// File: tb/tb_sha_block_unpack.sv
// tb_sha_block_unpack: random and directed blocks checked cycle-by-cycle against a padding model.
module tb_sha_block_unpack;
  logic clk = 0, reset = 0, go = 0;
  logic fin, err, ben, bwr, men, mwr;
  logic [6:0] len;
  logic [3:0] baddr;
  logic [5:0] maddr;
  logic [7:0] mdata;
  logic [31:0] bdata = 0;
  logic [31:0] mem [16];
  int n_chk = 0, n_fail = 0, cyc = 0, t_go = 0, fin_rel = 19, m_len = 0;
  bit active = 0, chk_on = 0, m_err = 0;

  sha_block_unpack dut (
    .clk(clk), .reset(reset), .xxx__dut__go(go),
    .dut__xxx__finish(fin), .dut__xxx__error(err), .dut__xxx__msg_length(len),
    .dut__bmem__address(baddr), .dut__bmem__enable(ben), .dut__bmem__write(bwr),
    .bmem__dut__data(bdata),
    .dut__msg__address(maddr), .dut__msg__data(mdata),
    .dut__msg__enable(men), .dut__msg__write(mwr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ben) bdata <= mem[baddr];

  function automatic logic [7:0] blk_byte(input int i);
    logic [31:0] w;
    w = mem[i/4];
    return w[31-8*(i%4) -: 8];
  endfunction

  function automatic void model(output bit e, output int l);
    logic [31:0] w15;
    w15 = mem[15];
    l = int'(w15 >> 3);
    e = mem[14] != 0 || w15[2:0] != 0 || l > 55;
    if (!e) begin
      if (blk_byte(l) != 8'h80) e = 1;
      for (int i = l + 1; i < 56; i++) if (blk_byte(i) != 8'h00) e = 1;
    end
    if (e) l = 0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    logic [31:0] w;
    w = mem[i/4];
    w[31-8*(i%4) -: 8] = v;
    mem[i/4] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 0;
  endtask

  task automatic load_abc();
    clear_mem();
    mem[0] = 32'h61626380;
    mem[15] = 32'h18;
  endtask

  task automatic go_run(input int exp_len, input bit exp_err, input int exp_lat, input string nm);
    int n;
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    n = 0;
    while (!fin && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, exp_lat);
    check({nm, " length"}, len, exp_len);
    check({nm, " error"}, err, exp_err);
    repeat (2) @(negedge clk);
  endtask

  // Model: go accepted when idle; timing follows the documented edge schedule.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) active = 0;
    else if (go && (!active || cyc - t_go > fin_rel)) begin
      active = 1;
      t_go = cyc;
      model(m_err, m_len);
      fin_rel = 19 + m_len;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      int rel, ba, ma;
      bit fe, be, me;
      logic [7:0] md;
      rel = cyc - t_go;
      fe = active && rel == fin_rel;
      be = active && rel <= 15;
      ba = be ? rel : 0;
      me = active && !m_err && rel >= 19 && rel < fin_rel;
      ma = me ? rel - 19 : 0;
      md = me ? blk_byte(ma) : 8'h00;
      check("strobes", {fin, ben, bwr, baddr, men, mwr, maddr, mdata},
            {fe, be, 1'b0, ba[3:0], me, me, ma[5:0], md});
      if (!active || rel >= fin_rel)
        check("status", {err, len}, active ? {m_err, 7'(m_len)} : 8'h00);
    end
  end

  initial begin
    clear_mem();
    repeat (3) @(negedge clk);
    chk_on = 1;
    @(negedge clk) reset = 1;
    load_abc();
    go_run(3, 0, 22, "abc");
    clear_mem();
    mem[0] = 32'h80000000;
    go_run(0, 0, 19, "empty");
    clear_mem();
    for (int i = 0; i < 55; i++) set_byte(i, 8'(i));
    set_byte(55, 8'h80);
    mem[15] = 32'h1B8;
    go_run(55, 0, 74, "max");
    load_abc(); mem[15] = 32'h19;
    go_run(0, 1, 19, "odd bits");
    load_abc(); mem[15] = 32'h1C0;
    go_run(0, 1, 19, "too long");
    load_abc(); mem[0] = 32'h61626300;
    go_run(0, 1, 19, "no marker");
    load_abc(); mem[14] = 32'h1;
    go_run(0, 1, 19, "word14");
    begin
      load_abc();
      @(negedge clk) go = 1;
      @(negedge clk) go = 0;
      repeat (20) @(negedge clk);
      reset = 0;
      @(posedge clk);
      #1 check("reset outputs", {fin, err, len, ben, bwr, baddr, men, mwr, maddr, mdata}, 0);
      @(negedge clk) reset = 1;
      repeat (30) @(negedge clk);
      go_run(3, 0, 22, "abc after reset");
    end
    begin
      int n;
      load_abc();
      @(negedge clk) go = 1;
      @(negedge clk) go = 0;
      repeat (4) @(negedge clk);
      go = 1;
      @(negedge clk) go = 0;
      repeat (14) @(negedge clk);
      go = 1;
      @(negedge clk) go = 0;
      repeat (2) @(negedge clk);
      check("pulse finish", fin, 1);
      go = 1;
      @(negedge clk) go = 0;
      n = 0;
      while (!fin && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("held go latency", n, 22);
      check("held go length", len, 3);
      check("held go error", err, 0);
      repeat (2) @(negedge clk);
    end
    repeat (24) begin
      int l, el;
      bit ee;
      l = $urandom_range(0, 55);
      clear_mem();
      for (int i = 0; i < l; i++) set_byte(i, 8'($urandom));
      set_byte(l, 8'h80);
      mem[15] = 32'(l) << 3;
      if ($urandom_range(0, 2) == 0) begin
        int bi;
        bi = $urandom_range(l, 63);
        set_byte(bi, blk_byte(bi) ^ (8'h1 << $urandom_range(0, 7)));
      end
      model(ee, el);
      go_run(el, ee, 19 + el, "random");
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sha_block_unpack.md
# sha_block_unpack

Reads one padded 512-bit SHA-256 message block (16 × 32-bit words) from a word-wide block memory, checks the padding, and writes the recovered message bytes into a byte-wide message memory. It is the inverse of the message-padding stage. It sits between the block memory and the message memory, and it reports the recovered length or a padding error.

## Interface
Parameters:
- MAX_MESSAGE_LENGTH, 55, maximum message length in bytes; also the depth of the message memory.
- BLOCK_WORDS, 16, number of 32-bit words per block.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- xxx__dut__go  in  1  start request; sampled only in IDLE.
- dut__xxx__finish  out  1  one-cycle completion pulse.
- dut__xxx__error  out  1  padding-check failure; valid from finish until the next accepted go.
- dut__xxx__msg_length  out  $clog2(MAX_MESSAGE_LENGTH)+1  recovered length L in bytes; 0 on error; same validity window as error.
- dut__bmem__address  out  $clog2(BLOCK_WORDS)  block-memory word address.
- dut__bmem__enable  out  1  block-memory access strobe.
- dut__bmem__write  out  1  tied 0; reads only.
- bmem__dut__data  in  32  block-memory read data.
- dut__msg__address  out  $clog2(MAX_MESSAGE_LENGTH)  message-memory byte address.
- dut__msg__data  out  8  message-memory write data.
- dut__msg__enable  out  1  message-memory strobe.
- dut__msg__write  out  1  message-memory write strobe.

## Operation
- Block byte order: byte i = B[511-8i -: 8]. Byte 0 is bits 31:24 of word 0.
- States and transitions:
  - IDLE: go=1 → READ.
  - READ: issue addresses 0..15; capture returning words into the 512-bit buffer. Last word stored → CHECK.
  - CHECK: one cycle. Pass with L>0 → WRITE. Pass with L=0, or fail → DONE.
  - WRITE: L consecutive byte writes, then → DONE.
  - DONE: finish=1 for one cycle → IDLE.
- Padding checks, all evaluated in CHECK from the buffer:
  - word 14 == 0;
  - word 15[2:0] == 0;
  - L = word15 >> 3, and L ≤ MAX_MESSAGE_LENGTH;
  - byte L == 8'h80;
  - bytes L+1 .. 55 all == 0.
- Any check failing sets error=1 and msg_length=0, and no message write occurs.
- On pass: error=0, msg_length=L. Write i (i = 0..L-1) carries address=i and data=byte i, with enable=write=1.
- Compute L from the full 32-bit word 15, so large values fail the range check instead of truncating.
- go while not in IDLE is ignored. go held high after DONE starts a new run from IDLE.
- Reset low at any edge, including mid-READ or mid-WRITE:
  - next state is IDLE and the buffer is cleared;
  - all outputs take their reset values at that edge;
  - a write in progress is abandoned.
- Reset values: finish=0, error=0, msg_length=0. All bmem and msg address, data, enable and write outputs are 0.

## Timing
- All outputs are registered.
- Block memory has a 1-cycle registered read. A word requested by outputs updated at edge e is stored into the buffer at edge e+2. There is no extra input register.
- Cycle sequence, with go sampled at edge t:
  - Reads: address k is driven from edge t+k (k = 0..15), with enable high for exactly 16 cycles. Enable drops at edge t+16.
  - Word 15 is stored at edge t+17.
  - CHECK result is registered at edge t+18.
  - Message writes are driven from edges t+19 .. t+18+L. Enable and write drop at edge t+19+L.
  - finish rises at edge t+19+L (t+19 for L=0 or error) and falls at the next edge.
- Minimum go-to-finish latency is 19 cycles; maximum is 74 cycles (L=55).

## Test plan
- "abc": word0=32'h61626380, words 1–14=0, word15=32'h18.
  - Writes 8'h61, 8'h62, 8'h63 to addresses 0–2 at edges t+19..t+21.
  - finish at t+22; msg_length=3, error=0.
- Empty message: word0=32'h80000000, all other words 0.
  - No msg strobes; finish at t+19; msg_length=0, error=0.
- Maximum length: bytes 0–54 = 8'h00..8'h36, byte 55=8'h80, word15=32'h1B8.
  - 55 writes, each with data equal to its address; finish at t+74.
- Error cases, each giving error=1, msg_length=0, no msg strobes, finish at t+19:
  - word15=32'h19 (not a byte multiple);
  - word15=32'h1C0 (L=56, over the limit);
  - "abc" with word0=32'h61626300 (missing 8'h80 marker);
  - "abc" with word 14 nonzero.
- Reset low for one cycle at t+21 during "abc".
  - All outputs are 0 at that edge and no further writes occur.
  - A later go runs "abc" cleanly with full timing.
- go pulsed at t+5 and t+20 during a run, then held high after finish.
  - The extra pulses are ignored.
  - The held go starts a second run exactly one cycle after DONE, with identical results.
